// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: default widths,
// PC increment, reset PC and FSM state encodings.
package fetch_pkg;

  localparam int PC_W_DEF   = 15;
  localparam int INST_W_DEF = 32;
  localparam int PC_STEP    = 4;

  localparam logic [PC_W_DEF-1:0] RESET_PC_DEF = '0;

  // FSM state encodings
  typedef logic [1:0] state_t;
  localparam state_t ST_BOOT   = 2'd0;
  localparam state_t ST_RUN    = 2'd1;
  localparam state_t ST_HALTED = 2'd2;
  localparam state_t ST_FAULT  = 2'd3;

endpackage

// File: rtl/fetch_out_stage.sv
// One-entry valid/ready output register between fetch and decode.
// flush empties the stage and wins over load; load captures a new word;
// otherwise an accepted word drains and a stalled word holds.
module fetch_out_stage
  import fetch_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int INST_W = INST_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              flush,
  input  logic              ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [PC_W-1:0]   in_pc,
  output logic              valid,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   pc
);

  logic              valid_q, valid_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [PC_W-1:0]   pc_q, pc_d;

  // Next-state of the output entry: flush, load, drain or hold
  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      inst_d  = in_inst;
      pc_d    = in_pc;
    end else if (ready) begin
      valid_d = 1'b0;
    end
  end

  // Output entry registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      inst_q  <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
    end
  end

  assign valid = valid_q;
  assign inst  = inst_q;
  assign pc    = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the combinational
// instruction memory address, and feeds decode through a one-entry
// valid/ready stage. Handles stall, redirect/flush and halt/resume.
// Optional macro FETCH_ALIGN_CHECK_EN: a misaligned redirect traps into a
// sticky FAULT state; without it the redirect target is word-aligned.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              INST_W   = INST_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   imem_pc,
  input  logic [INST_W-1:0] imem_data,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              halt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc,
  output logic              halted,
  output logic              fault
);

  localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] redirect_target;
  logic            load;
  logic            flush;
  logic            redir_bad;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q, fault_d;
  assign redir_bad       = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign redirect_target = redirect_pc;
`else
  // Low address bits are discarded when the alignment check is not built
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign redir_bad            = 1'b0;
  assign redirect_target      = {redirect_pc[PC_W-1:2], 2'b00};
`endif

  // FSM, next-PC selection and load/flush generation; redirect has top priority
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load    = 1'b0;
    flush   = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    fault_d = fault_q;
`endif
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (!redirect_valid) begin
          if (halt) begin
            state_d = ST_HALTED;
          end else if (!out_valid || out_ready) begin
            load = 1'b1;
            pc_d = pc_q + STEP;
          end
        end
      end
      ST_HALTED: begin
        if (!redirect_valid && !halt) state_d = ST_RUN;
      end
      default: state_d = state_q;
    endcase

    if (redirect_valid && (state_q != ST_FAULT)) begin
      flush = 1'b1;
      if (redir_bad) begin
        // Trap: keep the old pc so the faulting context is preserved
        state_d = ST_FAULT;
        pc_d    = pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
        fault_d = 1'b1;
`endif
      end else begin
        pc_d = redirect_target;
      end
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  // Sticky fault flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= fault_d;
  end
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  fetch_out_stage #(
    .PC_W   (PC_W),
    .INST_W (INST_W)
  ) u_out_stage (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .flush   (flush),
    .ready   (out_ready),
    .in_inst (imem_data),
    .in_pc   (pc_q),
    .valid   (out_valid),
    .inst    (out_inst),
    .pc      (out_pc)
  );

  assign imem_pc = pc_q;
  assign halted  = (state_q == ST_HALTED);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed table-driven bench for fetch_ctrl with a byte-wide little-endian
// instruction memory model; honours FETCH_ALIGN_CHECK_EN for the trap cases.
module tb_fetch_ctrl;

  localparam int PC_W   = 15;
  localparam int INST_W = 32;
  localparam int NVEC   = 28;

  logic              clk = 1'b0;
  logic              rst;
  logic [PC_W-1:0]   imem_pc;
  logic [INST_W-1:0] imem_data;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic              halt;
  logic              out_valid;
  logic              out_ready;
  logic [INST_W-1:0] out_inst;
  logic [PC_W-1:0]   out_pc;
  logic              halted;
  logic              fault;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem [0:(1<<PC_W)-1];

  typedef struct {
    logic        rst;
    logic        rv;
    logic [14:0] rpc;
    logic        halt;
    logic        rdy;
    logic        e_valid;
    logic        chk_data;
    logic [14:0] e_pc;
    logic [31:0] e_inst;
    logic [14:0] e_imem;
    logic        e_halted;
    logic        e_fault;
  } vec_t;

  vec_t vec [NVEC];

  fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .imem_pc        (imem_pc),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .halted         (halted),
    .fault          (fault)
  );

  always #5 clk = ~clk;

  // Combinational little-endian read, wrapping at the top of memory
  always_comb begin
    imem_data = {mem[PC_W'(imem_pc + 15'd3)], mem[PC_W'(imem_pc + 15'd2)],
                 mem[PC_W'(imem_pc + 15'd1)], mem[imem_pc]};
  end

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rv, input logic [14:0] rpc,
                       input logic h, input logic rdy);
    @(negedge clk);
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt           = h;
    out_ready      = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    logic [31:0] w;

    // Memory image: distinctive tag per word, two fixed words at the start
    for (int a = 0; a < (1 << PC_W); a += 4) begin
      w = 32'hC0DE_0000 | 32'(a);
      if (a == 0) w = 32'h1111_1111;
      if (a == 4) w = 32'h2222_2222;
      mem[a]   = w[7:0];
      mem[a+1] = w[15:8];
      mem[a+2] = w[23:16];
      mem[a+3] = w[31:24];
    end

    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0; out_ready = 1'b1;

    //            rst  rv   rpc       halt rdy  val  chk  e_pc      e_inst         e_imem    hlt  flt
    vec[0]  = '{1'b1, 1'b0, 15'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 15'h0000, 32'h0000_0000, 15'h0000, 1'b0, 1'b0};
    vec[1]  = '{1'b0, 1'b0, 15'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 15'h0000, 32'h0000_0000, 15'h0000, 1'b0, 1'b0};
    vec[2]  = '{1'b0, 1'b0, 15'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 15'h0000, 32'h1111_1111, 15'h0004, 1'b0, 1'b0};
    vec[3]  = '{1'b0, 1'b0, 15'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 15'h0004, 32'h2222_2222, 15'h0008, 1'b0, 1'b0};
    vec[4]  = '{1'b0, 1'b0, 15'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 15'h0008, 32'hC0DE_0008, 15'h000C, 1'b0, 1'b0};
    vec[5]  = '{1'b0, 1'b0, 15'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 15'h0008, 32'hC0DE_0008, 15'h000C, 1'b0, 1'b0};
    vec[6]  = '{1'b0, 1'b0, 15'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 15'h0008, 32'hC0DE_0008, 15'h000C, 1'b0, 1'b0};
    vec[7]  = '{1'b0, 1'b0, 15'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 15'h0008, 32'hC0DE_0008, 15'h000C, 1'b0, 1'b0};
    vec[8]  = '{1'b0, 1'b0, 15'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 15'h000C, 32'hC0DE_000C, 15'h0010, 1'b0, 1'b0};
    vec[9]  = '{1'b0, 1'b1, 15'h0100, 1'b0, 1'b1, 1'b0, 1'b0, 15'h0000, 32'h0000_0000, 15'h0100, 1'b0, 1'b0};
    vec[10] = '{1'b0, 1'b0, 15'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 15'h0100, 32'hC0DE_0100, 15'h0104, 1'b0, 1'b0};
    vec[11] = '{1'b0, 1'b1, 15'h7FFC, 1'b0, 1'b1, 1'b0, 1'b0, 15'h0000, 32'h0000_0000, 15'h7FFC, 1'b0, 1'b0};
    vec[12] = '{1'b0, 1'b0, 15'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 15'h7FFC, 32'hC0DE_7FFC, 15'h0000, 1'b0, 1'b0};
    vec[13] = '{1'b0, 1'b0, 15'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 15'h0000, 32'h1111_1111, 15'h0004, 1'b0, 1'b0};
    vec[14] = '{1'b0, 1'b0, 15'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 15'h0000, 32'h0000_0000, 15'h0004, 1'b1, 1'b0};
    vec[15] = '{1'b0, 1'b0, 15'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 15'h0000, 32'h0000_0000, 15'h0004, 1'b1, 1'b0};
    vec[16] = '{1'b0, 1'b0, 15'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 15'h0000, 32'h0000_0000, 15'h0004, 1'b1, 1'b0};
    vec[17] = '{1'b0, 1'b0, 15'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 15'h0000, 32'h0000_0000, 15'h0004, 1'b1, 1'b0};
    vec[18] = '{1'b0, 1'b0, 15'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 15'h0000, 32'h0000_0000, 15'h0004, 1'b0, 1'b0};
    vec[19] = '{1'b0, 1'b0, 15'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 15'h0004, 32'h2222_2222, 15'h0008, 1'b0, 1'b0};
    vec[20] = '{1'b0, 1'b0, 15'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 15'h0004, 32'h2222_2222, 15'h0008, 1'b1, 1'b0};
    vec[21] = '{1'b0, 1'b1, 15'h0200, 1'b1, 1'b1, 1'b0, 1'b0, 15'h0000, 32'h0000_0000, 15'h0200, 1'b1, 1'b0};
    vec[22] = '{1'b0, 1'b0, 15'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 15'h0000, 32'h0000_0000, 15'h0200, 1'b0, 1'b0};
    vec[23] = '{1'b0, 1'b0, 15'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 15'h0200, 32'hC0DE_0200, 15'h0204, 1'b0, 1'b0};
`ifdef FETCH_ALIGN_CHECK_EN
    vec[24] = '{1'b0, 1'b1, 15'h0102, 1'b0, 1'b1, 1'b0, 1'b0, 15'h0000, 32'h0000_0000, 15'h0204, 1'b0, 1'b1};
    vec[25] = '{1'b0, 1'b0, 15'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 15'h0000, 32'h0000_0000, 15'h0204, 1'b0, 1'b1};
    vec[26] = '{1'b0, 1'b1, 15'h0300, 1'b1, 1'b1, 1'b0, 1'b0, 15'h0000, 32'h0000_0000, 15'h0204, 1'b0, 1'b1};
`else
    vec[24] = '{1'b0, 1'b1, 15'h0102, 1'b0, 1'b1, 1'b0, 1'b0, 15'h0000, 32'h0000_0000, 15'h0100, 1'b0, 1'b0};
    vec[25] = '{1'b0, 1'b0, 15'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 15'h0100, 32'hC0DE_0100, 15'h0104, 1'b0, 1'b0};
    vec[26] = '{1'b0, 1'b1, 15'h0300, 1'b0, 1'b1, 1'b0, 1'b0, 15'h0000, 32'h0000_0000, 15'h0300, 1'b0, 1'b0};
`endif
    vec[27] = '{1'b1, 1'b0, 15'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 15'h0000, 32'h0000_0000, 15'h0000, 1'b0, 1'b0};

    for (int i = 0; i < NVEC; i++) begin
      drive(vec[i].rst, vec[i].rv, vec[i].rpc, vec[i].halt, vec[i].rdy);
      chk("out_valid", i, 32'(out_valid), 32'(vec[i].e_valid));
      chk("imem_pc",   i, 32'(imem_pc),   32'(vec[i].e_imem));
      chk("halted",    i, 32'(halted),    32'(vec[i].e_halted));
      chk("fault",     i, 32'(fault),     32'(vec[i].e_fault));
      if (vec[i].chk_data) begin
        chk("out_pc",   i, 32'(out_pc), 32'(vec[i].e_pc));
        chk("out_inst", i, out_inst,    vec[i].e_inst);
      end
    end

    // Reset release again, bounded wait for the first word (BOOT + 1 cycle)
    cyc = 0;
    drive(1'b0, 1'b0, 15'h0, 1'b0, 1'b1);
    cyc++;
    while (!out_valid && cyc < 10) begin
      drive(1'b0, 1'b0, 15'h0, 1'b0, 1'b1);
      cyc++;
    end
    chk("first_valid_timeout", 100, 32'(out_valid), 32'd1);
    chk("first_latency", 101, 32'(cyc), 32'd2);
    chk("first_pc", 102, 32'(out_pc), 32'h0);

    // Halt with a stalled word: the word stays held while halted
    drive(1'b0, 1'b0, 15'h0, 1'b1, 1'b0);
    chk("halt_hold_halted", 103, 32'(halted), 32'd1);
    chk("halt_hold_valid", 104, 32'(out_valid), 32'd1);
    chk("halt_hold_pc", 105, 32'(out_pc), 32'h0);
    chk("halt_hold_imem", 106, 32'(imem_pc), 32'h4);

    // Held word accepted while halted, no new load
    drive(1'b0, 1'b0, 15'h0, 1'b1, 1'b1);
    chk("halt_drain_valid", 107, 32'(out_valid), 32'd0);
    chk("halt_drain_imem", 108, 32'(imem_pc), 32'h4);

    // Reset mid-halt returns to reset state
    drive(1'b1, 1'b0, 15'h0, 1'b1, 1'b0);
    chk("rst_halt_halted", 109, 32'(halted), 32'd0);
    chk("rst_halt_valid", 110, 32'(out_valid), 32'd0);
    chk("rst_halt_imem", 111, 32'(imem_pc), 32'h0);
    chk("rst_halt_fault", 112, 32'(fault), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
